hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Producer of the ALU operand forwarding selects and load-use stall for the 5-stage pipeline. It keeps its own shadow pipeline of destination tags for the ID/EX, EX/MEM and MEM/WB stages and compares the source registers of the instruction in ID against them. The two registered 2-bit selects drive the ALU A and B operand muxes in EX. The combinational stall holds IF/ID and inserts a bubble into ID/EX.

## Interface
- No parameters.
- CLK  in  1  pipeline clock, rising edge
- RST  in  1  synchronous, active-high reset
- pipe_en  in  1  global pipeline advance (caches ready); 0 = every stage holds
- flush  in  1  branch/jump squash of the instruction in ID
- id_rs, id_rt  in  5 each  source registers of the ID instruction
- id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt
- id_rd  in  5  destination of the ID instruction, already muxed rd/rt/31
- id_regwrite, id_memread  in  1 each  ID instruction writes a register / is a load
- forwarda, forwardb  out  2 each  EX operand select: 00 ID/EX regfile value, 01 EX/MEM result, 10 MEM/WB writeback value; 11 never driven
- stall_id  out  1  hold PC and IF/ID; bubble into ID/EX
- stall_count  out  32  count of bubble cycles inserted, saturating

## Operation
- Stage tag = {valid, regwrite, memread, rd}. There are three registers: ex_tag, mem_tag, wb_tag.
- A match occurs when tag.valid, tag.regwrite, tag.rd == src, src != 0, and the use bit is set.
- stall_id is combinational and asserts when ex_tag.memread and ex_tag matches id_rs or id_rt. It is forced to 0 when flush=1.
- Advance happens when pipe_en=1: mem_tag <= ex_tag and wb_tag <= mem_tag.
- ex_tag loads on advance:
  - gets the ID tag when stall_id=0 and flush=0;
  - gets a bubble (valid=0) when stall_id=1 or flush=1.
- Select computed at advance for the instruction entering EX, per operand:
  - matches ex_tag → 01 (newest wins);
  - else matches mem_tag → 10;
  - else 00.
- A bubble entering EX loads 00/00.
- A load in EX/MEM is never a forward source. The load-use stall guarantees the load sits in MEM/WB, which selects 10.
- WB-stage matches are not forwarded: the register file writes before it reads.
- stall_count increments on each advance cycle with stall_id=1 and saturates at 0xFFFF_FFFF.
- With pipe_en=0, all registers, forwarda/forwardb and stall_count hold. stall_id is still evaluated.

## Timing
- Reset values:
  - all tags invalid;
  - forwarda=forwardb=00;
  - stall_count=0;
  - stall_id=0 from the first cycle after reset.
- forwarda/forwardb update on the same CLK edge as the ID/EX pipeline register. They are valid for the whole EX cycle.
- Load-use costs exactly one bubble cycle. On the following cycle, stall_id deasserts and the select is 10.
- Flush and stall in the same cycle: flush wins, one bubble, counter not incremented.
- RST mid-stream clears everything on the next edge regardless of pipe_en.

## Configuration
- HAZARD_FORWARD_EN defined (default build): forwarding behaves as described above.
- HAZARD_FORWARD_EN undefined:
  - forwarda/forwardb are constant 00;
  - stall_id asserts when the ID sources match ex_tag or mem_tag, regardless of memread, and is still masked by flush;
  - stalls repeat until the producer reaches WB;
  - stall_count counts every stall cycle.

## Structure
- cpu_types_pkg gains:
  - fwd_sel_t enum: FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10;
  - stage_tag_t packed struct {valid, regwrite, memread, regbits_t rd};
  - regbits_t, reused if already present.
- One sub-module, fwd_select, holds the priority match for one source register against two tags. It is instantiated twice (rs, rt).

## Test plan
- **EX/MEM forward.** Reset, then add $3←$1,$2 followed by sub $4←$3,$5 with pipe_en=1. Required: forwarda=01, forwardb=00 in the sub's EX cycle, and stall_id never asserts.
- **MEM/WB forward.** add $3, then an independent instruction, then or $6←$7,$3. Required: forwardb=10, forwarda=00.
- **Load-use.** lw $8 followed by add $9←$8,$8. Required: stall_id=1 for one cycle and stall_count=1. Next cycle: forwarda=forwardb=10.
- **$zero and no-write.** A write to $0, then a read of $0. Also sw (regwrite=0) with the same register number. Required: selects stay 00.
- **Hold, flush and saturation.** pipe_en=0 for 3 cycles during a load-use stall: selects and stall_count hold. flush=1 during a stall: ex bubble, counter unchanged. stall_count preloaded at 0xFFFF_FFFF via force: it stays there.
- **Build without HAZARD_FORWARD_EN.** add $3 followed by use of $3. Required: stall_id=1 for 2 cycles, selects always 00.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared pipeline types: register index, forward select, stage tag
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic     valid;
    logic     regwrite;
    logic     memread;
    regbits_t rd;
  } stage_tag_t;

  // An empty pipeline slot; reset and every inserted bubble use this value
  localparam stage_tag_t TAG_BUBBLE = '0;

  // A stage supplies a source only if it really writes that register and $0 is never a dependency
  function automatic logic tag_match(input stage_tag_t tag, input regbits_t src, input logic uses);
    return tag.valid && tag.regwrite && (tag.rd == src) && (src != '0) && uses;
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// rtl/hazard_forward_unit_if.sv - ID-stage request and EX forward/stall response bundle
interface hazard_forward_unit_if;
  import cpu_types_pkg::*;

  logic        pipe_en;
  logic        flush;
  regbits_t    id_rs;
  regbits_t    id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  regbits_t    id_rd;
  logic        id_regwrite;
  logic        id_memread;
  logic [1:0]  forwarda;
  logic [1:0]  forwardb;
  logic        stall_id;
  logic [31:0] stall_count;

  modport master (
    output pipe_en, flush, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_rd, id_regwrite, id_memread,
    input  forwarda, forwardb, stall_id, stall_count
  );

  modport slave (
    input  pipe_en, flush, id_rs, id_rt, id_uses_rs, id_uses_rt,
           id_rd, id_regwrite, id_memread,
    output forwarda, forwardb, stall_id, stall_count
  );

endinterface

// File: rtl/fwd_select.sv
// rtl/fwd_select.sv - priority match of one source register against the EX and MEM tags
module fwd_select
  import cpu_types_pkg::*;
(
  input  regbits_t   src,
  input  logic       uses,
  input  stage_tag_t ex_tag,
  input  stage_tag_t mem_tag,
  output logic       ex_hit,
  output logic       mem_hit,
  output fwd_sel_t   sel
);

  // Newest producer wins: the instruction currently in EX moves to EX/MEM on this advance
  always_comb begin
    ex_hit  = tag_match(ex_tag, src, uses);
    mem_hit = tag_match(mem_tag, src, uses);
    sel     = FWD_REG;
    if (ex_hit) begin
      sel = FWD_EXMEM;
    end else if (mem_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ALU forward selects and load-use stall; HAZARD_FORWARD_EN enables forwarding
module hazard_forward_unit
  import cpu_types_pkg::*;
(
  input logic                  CLK,
  input logic                  RST,
  hazard_forward_unit_if.slave hif
);

  stage_tag_t  ex_tag;
  stage_tag_t  mem_tag;
  stage_tag_t  wb_tag;
  stage_tag_t  id_tag;
  fwd_sel_t    fwda_q;
  fwd_sel_t    fwdb_q;
  fwd_sel_t    sel_a;
  fwd_sel_t    sel_b;
  logic        rs_ex_hit;
  logic        rs_mem_hit;
  logic        rt_ex_hit;
  logic        rt_mem_hit;
  logic        stall;
  logic        bubble;
  logic [31:0] stall_cnt;

  assign id_tag = '{valid: 1'b1, regwrite: hif.id_regwrite, memread: hif.id_memread, rd: hif.id_rd};

  fwd_select u_sel_rs (
    .src     (hif.id_rs),
    .uses    (hif.id_uses_rs),
    .ex_tag  (ex_tag),
    .mem_tag (mem_tag),
    .ex_hit  (rs_ex_hit),
    .mem_hit (rs_mem_hit),
    .sel     (sel_a)
  );

  fwd_select u_sel_rt (
    .src     (hif.id_rt),
    .uses    (hif.id_uses_rt),
    .ex_tag  (ex_tag),
    .mem_tag (mem_tag),
    .ex_hit  (rt_ex_hit),
    .mem_hit (rt_mem_hit),
    .sel     (sel_b)
  );

`ifdef HAZARD_FORWARD_EN
  // Only a load still in EX cannot be bypassed; one bubble moves it to MEM/WB
  assign stall = !hif.flush && ex_tag.memread && (rs_ex_hit || rt_ex_hit);
`else
  // Without bypass paths the consumer waits until the producer reaches WB; since every
  // EX/MEM hit stalls, the registered selects below can only ever load FWD_REG
  assign stall = !hif.flush && (rs_ex_hit || rt_ex_hit || rs_mem_hit || rt_mem_hit);
`endif

  assign bubble = stall || hif.flush;

  // Shadow tag pipeline, EX operand selects and saturating bubble counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_tag    <= TAG_BUBBLE;
      mem_tag   <= TAG_BUBBLE;
      wb_tag    <= TAG_BUBBLE;
      fwda_q    <= FWD_REG;
      fwdb_q    <= FWD_REG;
      stall_cnt <= '0;
    end else if (hif.pipe_en) begin
      mem_tag <= ex_tag;
      wb_tag  <= mem_tag;
      if (bubble) begin
        ex_tag <= TAG_BUBBLE;
        fwda_q <= FWD_REG;
        fwdb_q <= FWD_REG;
      end else begin
        ex_tag <= id_tag;
        fwda_q <= sel_a;
        fwdb_q <= sel_b;
      end
      if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

  assign hif.forwarda    = fwda_q;
  assign hif.forwardb    = fwdb_q;
  assign hif.stall_id    = stall;
  assign hif.stall_count = stall_cnt;

  // A slot that is not valid must be a clean bubble by the time it reaches WB
  a_wb_bubble_clean: assert property (@(posedge CLK) disable iff (RST)
    wb_tag.valid || (wb_tag == TAG_BUBBLE));

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed bench for hazard_forward_unit
module tb_hazard_forward_unit;
  import cpu_types_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;
  int   exp_cnt;

  hazard_forward_unit_if hif ();

  hazard_forward_unit dut (
    .CLK (clk),
    .RST (rst),
    .hif (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                        input logic [4:0] rd, input logic rw, input logic mr);
    hif.id_rs       = rs;
    hif.id_rt       = rt;
    hif.id_uses_rs  = urs;
    hif.id_uses_rt  = urt;
    hif.id_rd       = rd;
    hif.id_regwrite = rw;
    hif.id_memread  = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_cnt = 0;
    rst         = 1'b1;
    hif.pipe_en = 1'b1;
    hif.flush   = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_fwda", hif.forwarda, 2'b00);
    chk("rst_fwdb", hif.forwardb, 2'b00);
    chk("rst_stall", hif.stall_id, 1'b0);
    chk("rst_count", hif.stall_count, 32'd0);

    // add $3<-$1,$2 ; sub $4<-$3,$5
    set_id(1, 2, 1, 1, 3, 1, 0);
    chk("t1_add_stall", hif.stall_id, 1'b0);
    tick();
    set_id(3, 5, 1, 1, 4, 1, 0);
`ifdef HAZARD_FORWARD_EN
    chk("t1_sub_stall", hif.stall_id, 1'b0);
    tick();
    chk("t1_fwda", hif.forwarda, 2'b01);
    chk("t1_fwdb", hif.forwardb, 2'b00);
`else
    chk("t1_stall_c1", hif.stall_id, 1'b1);
    tick();
    exp_cnt++;
    chk("t1_stall_c2", hif.stall_id, 1'b1);
    chk("t1_bubble_fwda", hif.forwarda, 2'b00);
    tick();
    exp_cnt++;
    chk("t1_stall_c3", hif.stall_id, 1'b0);
    tick();
    chk("t1_fwda", hif.forwarda, 2'b00);
    chk("t1_fwdb", hif.forwardb, 2'b00);
`endif
    drain();
    chk("t1_count", hif.stall_count, exp_cnt);

    // add $3 ; and $10<-$11,$12 ; or $6<-$7,$3
    set_id(1, 2, 1, 1, 3, 1, 0);
    tick();
    set_id(11, 12, 1, 1, 10, 1, 0);
    tick();
    set_id(7, 3, 1, 1, 6, 1, 0);
`ifdef HAZARD_FORWARD_EN
    chk("t2_stall", hif.stall_id, 1'b0);
    tick();
    chk("t2_fwda", hif.forwarda, 2'b00);
    chk("t2_fwdb", hif.forwardb, 2'b10);
`else
    chk("t2_stall_c1", hif.stall_id, 1'b1);
    tick();
    exp_cnt++;
    chk("t2_stall_c2", hif.stall_id, 1'b0);
    tick();
    chk("t2_fwda", hif.forwarda, 2'b00);
    chk("t2_fwdb", hif.forwardb, 2'b00);
`endif
    drain();

    // lw $8,0($1) ; add $9<-$8,$8
    set_id(1, 0, 1, 0, 8, 1, 1);
    chk("t3_lw_stall", hif.stall_id, 1'b0);
    tick();
    set_id(8, 8, 1, 1, 9, 1, 0);
    chk("t3_stall_c1", hif.stall_id, 1'b1);
    tick();
    exp_cnt++;
`ifdef HAZARD_FORWARD_EN
    chk("t3_count", hif.stall_count, exp_cnt);
    chk("t3_stall_c2", hif.stall_id, 1'b0);
    chk("t3_bubble_fwda", hif.forwarda, 2'b00);
    tick();
    chk("t3_fwda", hif.forwarda, 2'b10);
    chk("t3_fwdb", hif.forwardb, 2'b10);
`else
    chk("t3_stall_c2", hif.stall_id, 1'b1);
    tick();
    exp_cnt++;
    chk("t3_stall_c3", hif.stall_id, 1'b0);
    tick();
    chk("t3_fwda", hif.forwarda, 2'b00);
    chk("t3_fwdb", hif.forwardb, 2'b00);
    chk("t3_count", hif.stall_count, exp_cnt);
`endif
    drain();

    // write $0 then read $0 ; sw with rd field $9 then read $9
    set_id(0, 0, 0, 0, 0, 1, 0);
    tick();
    set_id(0, 0, 1, 1, 5, 1, 0);
    chk("t4_r0_stall", hif.stall_id, 1'b0);
    tick();
    chk("t4_r0_fwda", hif.forwarda, 2'b00);
    chk("t4_r0_fwdb", hif.forwardb, 2'b00);
    set_id(1, 9, 1, 1, 9, 0, 0);
    tick();
    set_id(9, 9, 1, 1, 7, 1, 0);
    chk("t4_sw_stall", hif.stall_id, 1'b0);
    tick();
    chk("t4_sw_fwda", hif.forwarda, 2'b00);
    chk("t4_sw_fwdb", hif.forwardb, 2'b00);
    drain();

    // add $3 ; lw $8,0($3) ; add $9<-$8,$8 held for 3 cycles, then flushed
    set_id(1, 2, 1, 1, 3, 1, 0);
    tick();
    set_id(3, 0, 1, 0, 8, 1, 1);
`ifdef HAZARD_FORWARD_EN
    chk("t5_lw_stall", hif.stall_id, 1'b0);
    tick();
    chk("t5_lw_fwda", hif.forwarda, 2'b01);
`else
    chk("t5_lw_stall_c1", hif.stall_id, 1'b1);
    tick();
    exp_cnt++;
    chk("t5_lw_stall_c2", hif.stall_id, 1'b1);
    tick();
    exp_cnt++;
    chk("t5_lw_stall_c3", hif.stall_id, 1'b0);
    tick();
    chk("t5_lw_fwda", hif.forwarda, 2'b00);
`endif
    set_id(8, 8, 1, 1, 9, 1, 0);
    chk("t5_use_stall", hif.stall_id, 1'b1);
    hif.pipe_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_hold_stall_%0d", i), hif.stall_id, 1'b1);
      chk($sformatf("t5_hold_count_%0d", i), hif.stall_count, exp_cnt);
`ifdef HAZARD_FORWARD_EN
      chk($sformatf("t5_hold_fwda_%0d", i), hif.forwarda, 2'b01);
`else
      chk($sformatf("t5_hold_fwda_%0d", i), hif.forwarda, 2'b00);
`endif
    end
    hif.pipe_en = 1'b1;
    hif.flush   = 1'b1;
    #1;
    chk("t5_flush_stall", hif.stall_id, 1'b0);
    tick();
    chk("t5_flush_count", hif.stall_count, exp_cnt);
    chk("t5_flush_fwda", hif.forwarda, 2'b00);
    hif.flush = 1'b0;
    #1;
`ifdef HAZARD_FORWARD_EN
    chk("t5_post_flush_stall", hif.stall_id, 1'b0);
`else
    chk("t5_post_flush_stall", hif.stall_id, 1'b1);
`endif
    drain();

    // counter preloaded at all-ones must not wrap on further bubbles
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    #1;
    chk("t6_preload", hif.stall_count, 32'hFFFF_FFFF);
    set_id(1, 0, 1, 0, 8, 1, 1);
    tick();
    set_id(8, 8, 1, 1, 9, 1, 0);
    chk("t6_stall", hif.stall_id, 1'b1);
    tick();
    chk("t6_sat_1", hif.stall_count, 32'hFFFF_FFFF);
    tick();
    chk("t6_sat_2", hif.stall_count, 32'hFFFF_FFFF);
    drain();

    // reset while the pipeline is frozen in a load-use stall
    set_id(1, 0, 1, 0, 8, 1, 1);
    tick();
    set_id(8, 8, 1, 1, 9, 1, 0);
    chk("t7_stall_before", hif.stall_id, 1'b1);
    hif.pipe_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t7_rst_stall", hif.stall_id, 1'b0);
    chk("t7_rst_count", hif.stall_count, 32'd0);
    chk("t7_rst_fwda", hif.forwarda, 2'b00);
    chk("t7_rst_fwdb", hif.forwardb, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
